// File: rtl/ser_pkg.sv
// Shared types and defaults for the parallel-in/serial-out feeder.
// The SER_PARITY_EN build option is handled in piso_serializer itself.
package ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int   SER_WIDTH_DEF    = 8;
    localparam logic SER_IDLE_LVL_DEF = 1'b0;

endpackage

// File: rtl/piso_serializer.sv
// Double-buffered PISO serializer: valid/ready words in, MSB-first bit stream out.
// Define SER_PARITY_EN to append an even-parity bit after each word.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | nothing shifting, dout held at IDLE_LVL, holding reg empty
// SHIFT | a frame is being shifted out; holding reg may carry the next
module piso_serializer
    import ser_pkg::*;
#(
    parameter int   WIDTH    = SER_WIDTH_DEF,
    parameter logic IDLE_LVL = SER_IDLE_LVL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
`ifdef SER_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif
    localparam logic [CW-1:0] CNT_LOAD = CW'(SW - 1);

    // A frame is the data word plus, when enabled, its parity bit taken at load.
    function automatic logic [SW-1:0] frame_of(input logic [WIDTH-1:0] w);
`ifdef SER_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    ser_state_t       state;
    logic [SW-1:0]    shreg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic             xfer;

    assign in_ready = !hold_full;
    assign xfer     = in_valid && !hold_full;
    assign busy     = (state == SHIFT) || hold_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            dout       <= IDLE_LVL;
            dout_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        shreg      <= frame_of(in_data);
                        dout       <= in_data[WIDTH-1];
                        dout_valid <= 1'b1;
                        cnt        <= CNT_LOAD;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        shreg <= shreg << 1;
                        dout  <= shreg[SW-2];
                        cnt   <= cnt - 1'b1;
                        if (xfer) begin
                            hold      <= in_data;
                            hold_full <= 1'b1;
                        end
                    end else if (hold_full) begin
                        // in_ready is low here, so no new word can arrive this edge
                        shreg     <= frame_of(hold);
                        dout      <= hold[WIDTH-1];
                        cnt       <= CNT_LOAD;
                        hold_full <= 1'b0;
                    end else if (xfer) begin
                        shreg <= frame_of(in_data);
                        dout  <= in_data[WIDTH-1];
                        cnt   <= CNT_LOAD;
                    end else begin
                        dout       <= IDLE_LVL;
                        dout_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    dout       <= IDLE_LVL;
                    dout_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer against a word-schedule reference model.
module tb_piso_serializer;
    import ser_pkg::*;

    localparam int W    = 8;
`ifdef SER_PARITY_EN
    localparam int P    = W + 1;
`else
    localparam int P    = W;
`endif
    localparam int MAXE = 8192;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready, dout, dout_valid, busy;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .IDLE_LVL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .dout(dout), .dout_valid(dout_valid), .busy(busy)
    );

    int checks = 0;
    int failures = 0;
    int edge_n = 0;
    int lp;          // edge at which the most recent word started on the line
    bit hold_pend;
    int hl;          // edge at which the held word moves onto the line
    logic ev [MAXE];
    logic eb [MAXE];
    logic ebusy [MAXE];

    function automatic logic [P-1:0] frame(input logic [W-1:0] w);
`ifdef SER_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    task automatic model_clear();
        lp = -1000;
        hold_pend = 0;
        for (int i = edge_n + 1; i < MAXE; i++) begin
            ev[i] = 0; eb[i] = 0; ebusy[i] = 0;
        end
    endtask

    // One clock: drive inputs, check in_ready, take the edge, check outputs.
    task automatic drive_cycle(input logic v, input logic [W-1:0] d);
        int t, l;
        logic rdy;
        logic [P-1:0] f;
        t = edge_n + 1;
        rdy = !(hold_pend && t <= hl);
        in_valid = v;
        in_data  = d;
        #1;
        checks++;
        if (in_ready !== rdy) begin
            failures++;
            $display("FAIL in_ready edge=%0d got=%b exp=%b", t, in_ready, rdy);
        end
        @(posedge clk);
        edge_n = t;
        if (v && rdy && rst_n) begin
            l = (t > lp + P) ? t : lp + P;
            if (l > t) begin
                hold_pend = 1;
                hl = l;
                for (int e = t; e < l; e++) ebusy[e] = 1;
            end
            f = frame(d);
            for (int k = 0; k < P; k++) begin
                ev[l+k]    = 1;
                eb[l+k]    = f[P-1-k];
                ebusy[l+k] = 1;
            end
            lp = l;
        end
        @(negedge clk);
        checks++;
        if (dout_valid !== ev[edge_n]) begin
            failures++;
            $display("FAIL dout_valid edge=%0d got=%b exp=%b", edge_n, dout_valid, ev[edge_n]);
        end
        checks++;
        if (dout !== eb[edge_n]) begin
            failures++;
            $display("FAIL dout edge=%0d got=%b exp=%b", edge_n, dout, eb[edge_n]);
        end
        checks++;
        if (busy !== ebusy[edge_n]) begin
            failures++;
            $display("FAIL busy edge=%0d got=%b exp=%b", edge_n, busy, ebusy[edge_n]);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, W'($urandom));
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (dout !== 1'b0 || dout_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s got dout=%b dv=%b rdy=%b busy=%b exp 0 0 1 0",
                     tag, dout, dout_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        in_valid = 0;
        #2;
        check_reset_outputs("reset_state");
        @(negedge clk);
        edge_n = 1;
        model_clear();
        rst_n = 1;
        idle_cycles(3);
    endtask

    task automatic test_single();
        drive_cycle(1'b1, 8'b1011_0110);
        idle_cycles(P + 3);
    endtask

    task automatic test_back_to_back();
        drive_cycle(1'b1, 8'hB6);
        drive_cycle(1'b1, 8'h01);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 8'h01);
        drive_cycle(1'b1, 8'h5A);
        idle_cycles(3 * P);
    endtask

    task automatic test_bypass();
        drive_cycle(1'b1, 8'hC3);
        idle_cycles(P - 1);
        drive_cycle(1'b1, 8'h3C);
        idle_cycles(P + 2);
    endtask

    task automatic test_parity_words();
        drive_cycle(1'b1, 8'h07);
        drive_cycle(1'b1, 8'h03);
        idle_cycles(2 * P + 2);
    endtask

    task automatic test_reset_midword();
        drive_cycle(1'b1, 8'hE5);
        drive_cycle(1'b1, 8'h9B);
        idle_cycles(3);
        #2;
        rst_n = 0;
        #1;
        check_reset_outputs("reset_async_midword");
        model_clear();
        drive_cycle(1'b1, 8'hFF);
        drive_cycle(1'b0, 8'h00);
        rst_n = 1;
        idle_cycles(2 * P + 2);
    endtask

    task automatic test_random(input int n, input int pct);
        for (int i = 0; i < n; i++)
            drive_cycle(($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0, W'($urandom));
        idle_cycles(3 * P);
    endtask

    initial begin
        for (int i = 0; i < MAXE; i++) begin
            ev[i] = 0; eb[i] = 0; ebusy[i] = 0;
        end
        lp = -1000;
        hold_pend = 0;
        hl = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_bypass();
        test_parity_words();
        test_reset_midword();
        test_random(300, 30);
        test_random(300, 70);
        test_random(300, 100);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Upstream feeder for the serial sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock, MSB first, on a single-bit stream; that stream drives the detector's data input.
- Double-buffered (shift register plus one holding register), so consecutive words stream with no idle bit between them.

Parameters:
- WIDTH, 8, data bits per word (legal range 2..32).
- IDLE_LVL, 1'b0, level driven on dout when no bit is being sent.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial bit; feeds the detector's din.
- dout_valid  output  1  dout carries a payload bit this cycle.
- busy  output  1  shift register or holding register occupied.

Behaviour:
- Reset (async assert, sync-released use):
  - state=IDLE, dout=IDLE_LVL, dout_valid=0, in_ready=1, busy=0.
  - Holding register is empty; bit counter=0.
- Reset mid-word aborts the word. No partial bits are emitted after rst_n deasserts.
- Handshake:
  - A transfer occurs on a rising edge where in_valid=1 and in_ready=1.
  - in_ready = !hold_full, registered-state derived, with no combinational path from in_valid.
  - in_data may change freely when no transfer occurs.
- States: IDLE, SHIFT.
- IDLE:
  - On transfer at edge k, the word loads into the shift register and state moves to SHIFT.
  - After edge k: dout=in_data[WIDTH-1], dout_valid=1, counter=WIDTH-1. Latency is 1 cycle.
- SHIFT, each edge:
  - If counter!=0: shift left, dout=next bit, counter decrements.
  - Last bit is when counter==0, after WIDTH bits total.
- At the last-bit edge, priority order:
  - (a) hold_full: load from the holding register, hold_full clears, stay in SHIFT.
  - (b) transfer this edge with hold empty: load in_data directly (bypass), stay in SHIFT.
  - (c) otherwise: go to IDLE, dout=IDLE_LVL, dout_valid=0.
  - Cases (a) and (b) produce back-to-back words with zero gap.
- Transfer in SHIFT when not at the last bit: word goes to the holding register; hold_full=1 and in_ready=0 from the next cycle.
- Transfer at the last bit while hold_full is impossible, because in_ready=0.
- busy = (state==SHIFT) | hold_full.
- Counter width: $clog2(WIDTH+1). It never underflows; wrap is forbidden.
- dout and dout_valid are registered outputs, with no glitch paths to the detector.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra bit equal to ^word (even parity) is sent with dout_valid=1.
  - Word period becomes WIDTH+1 cycles.
  - The last-bit decision moves to the parity bit.
  - Parity is captured at load time.
- Undefined: no parity bit; word period is exactly WIDTH cycles.

Decomposition:
- Shared package ser_pkg holds:
  - state enum ser_state_t {IDLE, SHIFT};
  - the default WIDTH constant;
  - the IDLE_LVL default.
- No sub-module is natural: the holding register, shifter and counter are tightly coupled, so the block stays a single module.

Test Plan:
- Reset then idle: rst_n=0 → dout=0, dout_valid=0, in_ready=1, busy=0. Asserting rst_n asynchronously mid-cycle clears outputs immediately.
- Single word 8'b1011_0110 accepted at edge k → dout sequence 1,0,1,1,0,1,1,0 on cycles k+1..k+8 with dout_valid=1. IDLE at k+9 with dout=0, dout_valid=0.
- Back-to-back words 8'hB6 then 8'h01, in_valid held high:
  - 16 contiguous valid bits 10110110_00000001, no gap.
  - in_ready=0 while the second word is held.
  - in_ready=1 again after the second word loads.
- Bypass: second word presented exactly at the first word's last-bit edge with hold empty → loads directly, hold_full stays 0, no gap.
- Detector chain: stream bits 0,1,1 and 1,1,0 through the detector → detector flag pulses at the expected cycles (check alignment with the 1-cycle serializer latency).
- SER_PARITY_EN: word 8'h07 → 9 bits 00000111,1. Word 8'h03 → parity 0. Back-to-back period is 9 cycles.
